// File: rtl/alu_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : alu_arbiter_if
// Description: Bundle of every handshake and data signal between two
//              requesters, their result buffers, the shared ALU and the
//              alu_arbiter.
//              - slave  : the arbiter's view. It receives the requests, the
//                         result-consume strobes and the ALU outputs.
//              - master : the environment's view (requesters plus ALU).
//                         It drives the requests and the ALU outputs.
//              Port summary (N = 0, 1):
//                reqN_valid/ready      operation handshake
//                reqN_a/b [31:0]       operands
//                reqN_funct [3:0]      ALU function code, passed through
//                rspN_valid/ready      result handshake
//                rspN_o [31:0]         registered result
//                rspN_zero             registered zero flag
//                alu_a/b [31:0]        operands driven to the shared ALU
//                alu_funct [3:0]       function code driven to the ALU
//                alu_o [31:0]          combinational ALU result
//                alu_zero              combinational ALU zero flag
// Revision   : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
    // Requester 0
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_funct;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_o;
    logic        rsp0_zero;

    // Requester 1
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_funct;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_o;
    logic        rsp1_zero;

    // Shared ALU
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_funct;
    logic [31:0] alu_o;
    logic        alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_funct, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_funct, rsp1_ready,
        input  alu_o, alu_zero,
        output req0_ready, rsp0_valid, rsp0_o, rsp0_zero,
        output req1_ready, rsp1_valid, rsp1_o, rsp1_zero,
        output alu_a, alu_b, alu_funct
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_funct, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_funct, rsp1_ready,
        output alu_o, alu_zero,
        input  req0_ready, rsp0_valid, rsp0_o, rsp0_zero,
        input  req1_ready, rsp1_valid, rsp1_o, rsp1_zero,
        input  alu_a, alu_b, alu_funct
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : alu_arbiter
// Description: Shares one combinational ALU between two requesters. Each
//              cycle at most one eligible requester is granted. Its operands
//              go to the ALU, and the result is captured into that
//              requester's one-entry result buffer on the same edge.
//              A requester is eligible when it has a valid operation and its
//              result buffer is empty or is being drained this cycle.
//              Parameters:
//                FAIR  1 = round-robin on contention,
//                      0 = fixed priority, requester 0 highest
//              Ports:
//                clk   rising-edge clock
//                rst   asynchronous active-high reset
//                bus   alu_arbiter_if.slave (requests, results, ALU)
// Revision   : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_arbiter_if.slave bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        r_last_grant;   // index of the most recently granted requester
    logic        r_rsp0_valid;
    logic [31:0] r_rsp0_o;
    logic        r_rsp0_zero;
    logic        r_rsp1_valid;
    logic [31:0] r_rsp1_o;
    logic        r_rsp1_zero;

    // ------------------------------------------------------------------
    // Eligibility and grant
    // ------------------------------------------------------------------
    logic w_elig0;
    logic w_elig1;
    logic w_grant0;
    logic w_grant1;

    // A full buffer that is consumed this cycle frees its slot in time for
    // the new result, so draining and refilling can happen on one edge.
    assign w_elig0 = bus.req0_valid && (!r_rsp0_valid || bus.rsp0_ready);
    assign w_elig1 = bus.req1_valid && (!r_rsp1_valid || bus.rsp1_ready);

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        // No grant while reset is held. The reset is asynchronous, so an
        // in-cycle grant vanishes the moment rst rises.
        if (!rst) begin
            if (w_elig0 && w_elig1) begin
                // Round-robin: whoever did not win last time wins now.
                // After reset r_last_grant = 1, so requester 0 goes first.
                if (FAIR && (r_last_grant == 1'b0)) begin
                    w_grant1 = 1'b1;
                end else begin
                    w_grant0 = 1'b1;
                end
            end else begin
                w_grant0 = w_elig0;
                w_grant1 = w_elig1;
            end
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;

    // ------------------------------------------------------------------
    // ALU operand mux. Operands are zero when nobody is granted.
    // ------------------------------------------------------------------
    always_comb begin
        bus.alu_a     = 32'd0;
        bus.alu_b     = 32'd0;
        bus.alu_funct = 4'd0;
        if (w_grant0) begin
            bus.alu_a     = bus.req0_a;
            bus.alu_b     = bus.req0_b;
            bus.alu_funct = bus.req0_funct;
        end else if (w_grant1) begin
            bus.alu_a     = bus.req1_a;
            bus.alu_b     = bus.req1_b;
            bus.alu_funct = bus.req1_funct;
        end
    end

    // ------------------------------------------------------------------
    // Priority state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_grant0) begin
            r_last_grant <= 1'b0;
        end else if (w_grant1) begin
            r_last_grant <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result buffers. A grant takes precedence over a drain, so a
    // simultaneous drain and refill leaves valid set and keeps one op per
    // cycle of throughput.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_o     <= 32'd0;
            r_rsp0_zero  <= 1'b0;
        end else if (w_grant0) begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_o     <= bus.alu_o;
            r_rsp0_zero  <= bus.alu_zero;
        end else if (r_rsp0_valid && bus.rsp0_ready) begin
            r_rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp1_valid <= 1'b0;
            r_rsp1_o     <= 32'd0;
            r_rsp1_zero  <= 1'b0;
        end else if (w_grant1) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_o     <= bus.alu_o;
            r_rsp1_zero  <= bus.alu_zero;
        end else if (r_rsp1_valid && bus.rsp1_ready) begin
            r_rsp1_valid <= 1'b0;
        end
    end

    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp0_o     = r_rsp0_o;
    assign bus.rsp0_zero  = r_rsp0_zero;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp1_o     = r_rsp1_o;
    assign bus.rsp1_zero  = r_rsp1_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tb_alu_arbiter
// Description: Self-checking bench for alu_arbiter. It contains a reference
//              ALU, a grant/occupancy model and per-requester result
//              scoreboards. It drives a round-robin instance through
//              directed and random traffic, plus a fixed-priority instance
//              for contention.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] o;
        logic        z;
    } res_t;

    res_t q0[$];
    res_t q1[$];

    // Reference ALU used both as the environment's ALU and for expectations
    function automatic logic [31:0] alu_model(logic [31:0] a, logic [31:0] b, logic [3:0] f);
        case (f)
            4'h0:    return a + b;
            4'h1:    return a & b;
            4'h2:    return a | b;
            4'h3:    return a ^ b;
            4'h8:    return a - b;
            default: return {31'd0, (a < b)};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Round-robin instance
    // ------------------------------------------------------------------
    alu_arbiter_if bus ();
    assign bus.alu_o    = alu_model(bus.alu_a, bus.alu_b, bus.alu_funct);
    assign bus.alu_zero = (bus.alu_o == 32'd0);

    alu_arbiter #(.FAIR(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ------------------------------------------------------------------
    // Fixed-priority instance (contention only)
    // ------------------------------------------------------------------
    alu_arbiter_if fbus ();
    assign fbus.alu_o    = alu_model(fbus.alu_a, fbus.alu_b, fbus.alu_funct);
    assign fbus.alu_zero = (fbus.alu_o == 32'd0);

    alu_arbiter #(.FAIR(1'b0)) u_fixed (
        .clk (clk),
        .rst (rst),
        .bus (fbus.slave)
    );

    logic fx_en = 1'b0;
    always_comb begin
        fbus.req0_valid = fx_en;
        fbus.req1_valid = fx_en;
        fbus.req0_a     = 32'd1;
        fbus.req0_b     = 32'd2;
        fbus.req0_funct = 4'h0;
        fbus.req1_a     = 32'd3;
        fbus.req1_b     = 32'd4;
        fbus.req1_funct = 4'h0;
        fbus.rsp0_ready = 1'b1;
        fbus.rsp1_ready = 1'b1;
    end

    // ------------------------------------------------------------------
    // Monitor: grant model plus scoreboard, sampled on the falling edge
    // ------------------------------------------------------------------
    logic mv0, mv1, mlast;
    logic e0, e1, g0, g1;
    res_t exp_r;

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            mv0   = 1'b0;
            mv1   = 1'b0;
            mlast = 1'b1;
            check("rst_rdy0", bus.req0_ready, 0);
            check("rst_rdy1", bus.req1_ready, 0);
            check("rst_v0", bus.rsp0_valid, 0);
            check("rst_v1", bus.rsp1_valid, 0);
        end else begin
            e0 = bus.req0_valid && (!mv0 || bus.rsp0_ready);
            e1 = bus.req1_valid && (!mv1 || bus.rsp1_ready);
            if (e0 && e1) begin
                g0 = mlast;
                g1 = !mlast;
            end else begin
                g0 = e0;
                g1 = e1;
            end
            check("rdy0", bus.req0_ready, g0);
            check("rdy1", bus.req1_ready, g1);
            check("v0", bus.rsp0_valid, mv0);
            check("v1", bus.rsp1_valid, mv1);

            if (mv0 && bus.rsp0_ready) begin
                check("sb0_avail", q0.size() != 0, 1);
                if (q0.size() != 0) begin
                    exp_r = q0.pop_front();
                    check("rsp0_o", bus.rsp0_o, exp_r.o);
                    check("rsp0_zero", bus.rsp0_zero, exp_r.z);
                end
            end
            if (mv1 && bus.rsp1_ready) begin
                check("sb1_avail", q1.size() != 0, 1);
                if (q1.size() != 0) begin
                    exp_r = q1.pop_front();
                    check("rsp1_o", bus.rsp1_o, exp_r.o);
                    check("rsp1_zero", bus.rsp1_zero, exp_r.z);
                end
            end

            if (g0) begin
                check("alu_a0", bus.alu_a, bus.req0_a);
                check("alu_f0", bus.alu_funct, bus.req0_funct);
                exp_r.o = alu_model(bus.req0_a, bus.req0_b, bus.req0_funct);
                exp_r.z = (exp_r.o == 32'd0);
                q0.push_back(exp_r);
            end else if (g1) begin
                check("alu_b1", bus.alu_b, bus.req1_b);
                check("alu_f1", bus.alu_funct, bus.req1_funct);
                exp_r.o = alu_model(bus.req1_a, bus.req1_b, bus.req1_funct);
                exp_r.z = (exp_r.o == 32'd0);
                q1.push_back(exp_r);
            end else begin
                check("alu_idle", bus.alu_a | bus.alu_b | {28'd0, bus.alu_funct}, 0);
            end

            mv0 = g0 ? 1'b1 : (bus.rsp0_ready ? 1'b0 : mv0);
            mv1 = g1 ? 1'b1 : (bus.rsp1_ready ? 1'b0 : mv1);
            if (g0)      mlast = 1'b0;
            else if (g1) mlast = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.req0_valid = 1'b1;   // asserted during reset: must not be granted
        bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_funct = 4'h8;
        bus.req1_valid = 1'b0;
        bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_funct = 4'h0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_o0", bus.rsp0_o, 0);
        check("rst_z0", bus.rsp0_zero, 0);
        check("rst_o1", bus.rsp1_o, 0);

        // Single op in the first cycle after reset: 5 - 3 = 2
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("single_rdy", bus.req0_ready, 1);
        check("single_alu_a", bus.alu_a, 5);
        check("single_alu_b", bus.alu_b, 3);
        check("single_alu_f", bus.alu_funct, 4'h8);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("single_v", bus.rsp0_valid, 1);
        check("single_o", bus.rsp0_o, 2);
        check("single_z", bus.rsp0_zero, 0);

        // Backpressure on requester 1: 10 + 4 = 14 is held
        tick();
        bus.rsp0_ready = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_a = 32'd10; bus.req1_b = 32'd4; bus.req1_funct = 4'h0;
        bus.rsp1_ready = 1'b0;
        @(negedge clk);
        check("bp_first_rdy1", bus.req1_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.req1_a = 32'd99;
            bus.req0_valid = 1'b1;
            bus.req0_a = 32'(i * 3 + 1); bus.req0_b = 32'(i); bus.req0_funct = 4'h0;
            @(negedge clk);
            check("bp_rdy0", bus.req0_ready, 1);
            check("bp_rdy1", bus.req1_ready, 0);
            check("bp_v1", bus.rsp1_valid, 1);
            check("bp_o1", bus.rsp1_o, 14);
        end

        // Drain and refill requester 0 on the same edge: 7 - 7 = 0
        tick();
        bus.req1_valid = 1'b0;
        bus.rsp1_ready = 1'b1;
        bus.req0_a = 32'd7; bus.req0_b = 32'd7; bus.req0_funct = 4'h8;
        @(negedge clk);
        check("dr_v0_before", bus.rsp0_valid, 1);
        check("dr_rdy0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.rsp0_ready = 1'b0;
        @(negedge clk);
        check("dr_v0", bus.rsp0_valid, 1);
        check("dr_o0", bus.rsp0_o, 0);
        check("dr_z0", bus.rsp0_zero, 1);

        // Reset pulsed on a grant cycle
        tick();
        bus.rsp0_ready = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_funct = 4'h0;
        @(negedge clk);
        check("rm_rdy0", bus.req0_ready, 1);
        tick();
        bus.req0_a = 32'd20; bus.req0_b = 32'd22;
        #2;
        rst = 1'b1;
        #1;
        check("rm_rdy_gated", bus.req0_ready, 0);
        tick();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("rm_v0", bus.rsp0_valid, 0);
        check("rm_o0", bus.rsp0_o, 0);
        check("rm_z0", bus.rsp0_zero, 0);
        tick();
        @(negedge clk);
        check("rm_no_pulse", bus.rsp0_valid, 0);

        // Contention: round-robin 0,1,0,1 and fixed priority 0,0,0,0
        tick();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        fx_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_rdy0", bus.req0_ready, (i % 2) == 0);
            check("rr_rdy1", bus.req1_ready, (i % 2) == 1);
            check("fx_rdy0", fbus.req0_ready, 1);
            check("fx_rdy1", fbus.req1_ready, 0);
            tick();
        end
        fx_en = 1'b0;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.req0_valid = ($urandom_range(0, 3) != 0);
            bus.req1_valid = ($urandom_range(0, 3) != 0);
            bus.req0_a = $urandom;
            bus.req0_b = ($urandom_range(0, 7) == 0) ? bus.req0_a : $urandom;
            bus.req0_funct = 4'($urandom_range(0, 15));
            bus.req1_a = $urandom_range(0, 255);
            bus.req1_b = $urandom_range(0, 255);
            bus.req1_funct = 4'($urandom_range(0, 15));
            bus.rsp0_ready = ($urandom_range(0, 9) < 7);
            bus.rsp1_ready = ($urandom_range(0, 9) < 5);
            tick();
        end

        // Drain everything
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("sb_drained", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
